lp_rx_deser: RTL and testbench
==============================

Name: lp_rx_deser

Overview:
- Receive-side deserializer directly downstream of the lightpipe DPLL.
- Consumes the DPLL's recovered bitclock and locked flag plus the raw word clock (wc) and the serial data line.
- Samples sdata on each bitclock rising edge, aligns bit 0 to the wc rising edge, and packs bits MSB-first into bytes.
- Delivers bytes over a one-deep valid/ready interface and reports per-frame bit-count integrity.

Parameters:
FRAMEBITS, 256, serial bits expected per wc period; legal range 8..511, must be a multiple of 8.
BYTEW, 8, output word width in bits; fixed at 8, listed for documentation only.

Ports:
clk  in  1  system clock; all inputs are synchronous to it.
reset  in  1  synchronous reset, active-high.
wc  in  1  word/frame clock; a rising edge marks frame start.
bitclock  in  1  recovered bit clock from the DPLL.
locked  in  1  DPLL lock indication.
sdata  in  1  serial data, valid on bitclock rising edges.
out_data  out  8  received byte.
out_sof  out  1  qualifies out_data as the first byte of a frame.
out_valid  out  1  byte available.
out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
frame_ok  out  1  one-cycle pulse: the previous frame held exactly FRAMEBITS bits.
frame_err  out  1  one-cycle pulse: the previous frame held too few or too many bits.
overrun  out  1  sticky: a completed byte was dropped because the holding register was full.

Behaviour:
- Edge detect:
  - wc_rise = wc & ~wc_d; bit_stb = bitclock & ~bc_d.
  - wc_d and bc_d are registered copies of the inputs; both reset to 0.
  - sdata is sampled in the bit_stb cycle.
- Reset values: out_data=0, out_sof=0, out_valid=0, frame_ok=0, frame_err=0, overrun=0, state=UNLOCKED, bitcnt=0, shreg=0, extra=0.
- State UNLOCKED:
  - bit_stb and wc_rise are ignored.
  - locked=1 -> HUNT.
- State HUNT:
  - bit_stb is ignored.
  - wc_rise -> SHIFT with bitcnt=0.
  - A bit_stb in the same cycle as wc_rise is captured as bit 0 of the new frame.
- State SHIFT:
  - On bit_stb with bitcnt<FRAMEBITS: shreg <= {shreg[6:0], sdata}; bitcnt++ (9-bit counter).
  - On bit_stb with bitcnt==FRAMEBITS: no shift; extra<=1.
- State SHIFT, on wc_rise:
  - If bitcnt==FRAMEBITS && !extra: pulse frame_ok. Otherwise pulse frame_err.
  - Discard any partial byte; clear extra; bitcnt<=0; stay in SHIFT.
  - A simultaneous bit_stb is bit 0 of the new frame (bitcnt<=1).
- Any state, locked=0:
  - Next state is UNLOCKED; partial byte and bitcnt are discarded.
  - No frame_ok/frame_err pulse.
  - A byte already in the holding register stays valid until accepted.
- Byte completion: a bit_stb in SHIFT that makes bitcnt[2:0] wrap to 0.
  - out_data <= {shreg[6:0], sdata}, i.e. first received bit is the MSB.
  - out_sof <= (new bitcnt==8).
  - out_valid <= 1.
  - All three are visible the cycle after the strobe (latency 1 clk from the 8th bit's strobe).
- Handshake:
  - out_valid drops the cycle after out_valid&&out_ready unless a new byte loads in the same cycle.
  - Load and accept in the same cycle: the new byte replaces the old; out_valid stays 1.
  - Byte completes while out_valid && !out_ready: the byte is dropped; overrun <= 1 until reset.
  - out_data and out_sof are stable while out_valid && !out_ready.
- frame_ok and frame_err are never asserted together; both are 0 in every other cycle.
- Reset wins over all other events in the same cycle.

Test Plan:
- Nominal lock: reset 2 clk; locked=1; wc rise; 256 strobes (each 1 clk high, 4 clk low) carrying bytes 0x00..0x1F; out_ready=1; second wc rise.
  -> 32 bytes 0x00..0x1F in order, out_sof only on 0x00, frame_ok single pulse on the cycle after the second wc rise, frame_err=0.
- MSB order and latency: send 1,0,1,0,0,1,0,1.
  -> out_data=0xA5 with out_valid high exactly 1 clk after the 8th strobe cycle.
- Short/long frame:
  - 250 bits then wc rise -> frame_err pulse, last 2 bits never appear on out_data.
  - 260 bits then wc rise -> frame_err pulse, exactly 32 bytes delivered.
- Backpressure: out_ready=0 across two byte completions.
  -> first byte held unchanged, second dropped, overrun=1 and stays 1.
  - Then out_ready=1 -> first byte accepted, out_valid=0 the next cycle.
- Simultaneous events: bit_stb coincident with wc rise.
  -> counted as bit 0 of the new frame, previous frame judged on its own count.
  - Same-cycle accept and load -> no gap in out_valid.
- Lock loss and reset mid-frame:
  - Drop locked after 100 bits -> no frame pulse, no partial byte, HUNT after relock waits for wc.
  - Assert reset mid-byte -> all outputs 0 next cycle, including overrun.

Source files
------------

// File: rtl/lp_rx_deser.sv
// Receive deserializer behind the lightpipe DPLL: samples sdata on bitclock rises,
// frames on wc rises, packs MSB-first bytes and reports per-frame bit-count integrity.
module lp_rx_deser #(
    parameter int FRAMEBITS = 256,
    parameter int BYTEW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wc,
    input  logic             bitclock,
    input  logic             locked,
    input  logic             sdata,
    output logic [BYTEW-1:0] out_data,
    output logic             out_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_ok,
    output logic             frame_err,
    output logic             overrun
);
    localparam logic [8:0] FB = 9'(FRAMEBITS);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_HUNT, ST_SHIFT} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_wc_d, r_bc_d;
    logic [8:0]       r_bitcnt, w_bitcnt_nxt;
    logic [BYTEW-1:0] r_shreg, w_shreg_nxt;
    logic             r_extra, w_extra_nxt;
    logic             w_wc_rise, w_bit_stb;
    logic             w_byte_done, w_frame_ok, w_frame_err;
    logic [BYTEW-1:0] w_shift_in;

    assign w_wc_rise  = wc & ~r_wc_d;
    assign w_bit_stb  = bitclock & ~r_bc_d;
    assign w_shift_in = {r_shreg[BYTEW-2:0], sdata};

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shreg_nxt  = r_shreg;
        w_extra_nxt  = r_extra;
        w_byte_done  = 1'b0;
        w_frame_ok   = 1'b0;
        w_frame_err  = 1'b0;
        if (!locked) begin
            w_state_nxt  = ST_UNLOCKED;
            w_bitcnt_nxt = '0;
            w_extra_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_UNLOCKED: w_state_nxt = ST_HUNT;
                ST_HUNT: begin
                    if (w_wc_rise) begin
                        w_state_nxt  = ST_SHIFT;
                        w_extra_nxt  = 1'b0;
                        w_bitcnt_nxt = w_bit_stb ? 9'd1 : 9'd0;
                        if (w_bit_stb) w_shreg_nxt = w_shift_in;
                    end
                end
                ST_SHIFT: begin
                    if (w_wc_rise) begin
                        // A strobe coincident with wc belongs to the new frame.
                        w_frame_ok   = (r_bitcnt == FB) && !r_extra;
                        w_frame_err  = !((r_bitcnt == FB) && !r_extra);
                        w_extra_nxt  = 1'b0;
                        w_bitcnt_nxt = w_bit_stb ? 9'd1 : 9'd0;
                        if (w_bit_stb) w_shreg_nxt = w_shift_in;
                    end else if (w_bit_stb) begin
                        if (r_bitcnt < FB) begin
                            w_shreg_nxt  = w_shift_in;
                            w_bitcnt_nxt = r_bitcnt + 9'd1;
                            w_byte_done  = (r_bitcnt[2:0] == 3'd7);
                        end else begin
                            w_extra_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_UNLOCKED;
            r_wc_d    <= 1'b0;
            r_bc_d    <= 1'b0;
            r_bitcnt  <= '0;
            r_shreg   <= '0;
            r_extra   <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_valid <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wc_d    <= wc;
            r_bc_d    <= bitclock;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_extra   <= w_extra_nxt;
            frame_ok  <= w_frame_ok;
            frame_err <= w_frame_err;
            // One-deep holding register: a load may replace a byte accepted this cycle.
            if (w_byte_done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= w_shift_in;
                    out_sof   <= (r_bitcnt == 9'd7);
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lp_rx_deser.sv
// Randomized self-checking bench for lp_rx_deser; expected bytes come from grouping
// the transmitted bit stream into MSB-first octets, capped at FRAMEBITS per frame.
module tb_lp_rx_deser;
    localparam int FB = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wc = 1'b0, bitclock = 1'b0, locked = 1'b0, sdata = 1'b0, out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_sof, out_valid, frame_ok, frame_err, overrun;

    lp_rx_deser #(.FRAMEBITS(FB), .BYTEW(8)) dut (
        .clk(clk), .reset(reset), .wc(wc), .bitclock(bitclock), .locked(locked),
        .sdata(sdata), .out_data(out_data), .out_sof(out_sof), .out_valid(out_valid),
        .out_ready(out_ready), .frame_ok(frame_ok), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    logic [8:0] got[$];
    int ok_cnt = 0, err_cnt = 0, both_cnt = 0;

    // Monitor: every cycle with valid&&ready at the next edge is one accepted byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) got.push_back({out_sof, out_data});
            if (frame_ok) ok_cnt++;
            if (frame_err) err_cnt++;
            if (frame_ok && frame_err) both_cnt++;
        end
    end

    function automatic logic [7:0] ref_byte(input bit bq[$], input int k);
        int v = 0;
        for (int j = 0; j < 8; j++) v = v * 2 + int'(bq[8*k+j]);
        return 8'(v);
    endfunction

    function automatic int ref_nbytes(input int nbits);
        return ((nbits < FB) ? nbits : FB) / 8;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        sdata = b; bitclock = 1'b1; tick(1);
        bitclock = 1'b0; tick(4);
    endtask

    task automatic send_bits(input bit bq[$]);
        foreach (bq[i]) send_bit(bq[i]);
    endtask

    task automatic wc_edge(input bit has_bit, input bit b);
        wc = 1'b1;
        if (has_bit) begin bitclock = 1'b1; sdata = b; end
        tick(1);
        wc = 1'b0; bitclock = 1'b0; tick(4);
    endtask

    task automatic rand_bits(output bit bq[$], input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(bit'($urandom_range(1, 0)));
    endtask

    task automatic start();
        reset = 1'b1; locked = 1'b0; wc = 1'b0; bitclock = 1'b0; out_ready = 1'b1;
        tick(2);
        reset = 1'b0; locked = 1'b1;
        tick(2);
        wc_edge(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(2);
        n_checks++;
        if ({out_data, out_sof, out_valid, frame_ok, frame_err, overrun} !== 13'd0) begin
            n_fail++; $display("FAIL reset_state: got %h expected 0",
                {out_data, out_sof, out_valid, frame_ok, frame_err, overrun});
        end
    endtask

    task automatic test_nominal();
        bit bq[$];
        int gb, ob, eb;
        start();
        gb = got.size(); ob = ok_cnt; eb = err_cnt;
        for (int b = 0; b < 32; b++) for (int j = 7; j >= 0; j--) bq.push_back(bit'((b >> j) & 1));
        send_bits(bq);
        wc = 1'b1;
        n_checks++;
        if (frame_ok !== 1'b0) begin n_fail++; $display("FAIL ok_early: got %b expected 0", frame_ok); end
        tick(1);
        wc = 1'b0;
        n_checks++;
        if ({frame_ok, frame_err} !== 2'b10) begin
            n_fail++; $display("FAIL ok_pulse: got ok/err %b%b expected 10", frame_ok, frame_err);
        end
        tick(1);
        n_checks++;
        if (frame_ok !== 1'b0) begin n_fail++; $display("FAIL ok_width: got %b expected 0", frame_ok); end
        tick(3);
        n_checks++;
        if (got.size() - gb !== 32) begin n_fail++; $display("FAIL nom_count: got %0d expected 32", got.size() - gb); end
        for (int k = 0; k < 32 && gb + k < got.size(); k++) begin
            n_checks++;
            if (got[gb+k] !== {k == 0, 8'(k)}) begin
                n_fail++; $display("FAIL nom_byte%0d: got %h expected %h", k, got[gb+k], {k == 0, 8'(k)});
            end
        end
        n_checks++;
        if (ok_cnt - ob !== 1 || err_cnt - eb !== 0) begin
            n_fail++; $display("FAIL nom_pulses: got ok %0d err %0d expected 1 0", ok_cnt - ob, err_cnt - eb);
        end
        // Random payload frame following straight after.
        gb = got.size(); ob = ok_cnt;
        rand_bits(bq, FB);
        send_bits(bq);
        wc_edge(1'b0, 1'b0);
        n_checks++;
        if (got.size() - gb !== 32 || ok_cnt - ob !== 1) begin
            n_fail++; $display("FAIL rnd_frame: got %0d bytes %0d ok expected 32 1", got.size() - gb, ok_cnt - ob);
        end
        for (int k = 0; k < 32 && gb + k < got.size(); k++) begin
            n_checks++;
            if (got[gb+k] !== {k == 0, ref_byte(bq, k)}) begin
                n_fail++; $display("FAIL rnd_byte%0d: got %h expected %h", k, got[gb+k], {k == 0, ref_byte(bq, k)});
            end
        end
    endtask

    task automatic test_msb_latency();
        bit pat[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        start();
        for (int i = 0; i < 7; i++) send_bit(pat[i]);
        sdata = pat[7]; bitclock = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL msb_early: got valid %b expected 0", out_valid); end
        tick(1);
        n_checks++;
        if ({out_valid, out_sof, out_data} !== {2'b11, 8'hA5}) begin
            n_fail++; $display("FAIL msb_byte: got %b %b %h expected 1 1 a5", out_valid, out_sof, out_data);
        end
        bitclock = 1'b0; tick(4);
    endtask

    task automatic test_short_long();
        bit bq[$];
        int gb, ob, eb, nb;
        int lens[2] = '{250, 260};
        start();
        foreach (lens[t]) begin
            gb = got.size(); ob = ok_cnt; eb = err_cnt;
            rand_bits(bq, lens[t]);
            send_bits(bq);
            wc_edge(1'b0, 1'b0);
            nb = ref_nbytes(lens[t]);
            n_checks++;
            if (got.size() - gb !== nb || err_cnt - eb !== 1 || ok_cnt - ob !== 0) begin
                n_fail++; $display("FAIL len%0d: got %0d bytes err %0d ok %0d expected %0d 1 0",
                    lens[t], got.size() - gb, err_cnt - eb, ok_cnt - ob, nb);
            end
            for (int k = 0; k < nb && gb + k < got.size(); k++) begin
                n_checks++;
                if (got[gb+k] !== {k == 0, ref_byte(bq, k)}) begin
                    n_fail++; $display("FAIL len%0d_byte%0d: got %h expected %h", lens[t], k, got[gb+k], {k == 0, ref_byte(bq, k)});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit bq[$];
        int gb;
        start();
        gb = got.size();
        rand_bits(bq, 16);
        out_ready = 1'b0;
        send_bits(bq);
        n_checks++;
        if ({out_valid, out_sof, out_data, overrun} !== {2'b11, ref_byte(bq, 0), 1'b1}) begin
            n_fail++; $display("FAIL bp_hold: got %b %b %h ovr %b expected 1 1 %h 1",
                out_valid, out_sof, out_data, overrun, ref_byte(bq, 0));
        end
        tick(3);
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, ref_byte(bq, 0)}) begin
            n_fail++; $display("FAIL bp_stable: got %b %h expected 1 %h", out_valid, out_data, ref_byte(bq, 0));
        end
        out_ready = 1'b1;
        tick(1);
        n_checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got valid %b ovr %b expected 0 1", out_valid, overrun);
        end
        n_checks++;
        if (got.size() - gb !== 1 || got[gb] !== {1'b1, ref_byte(bq, 0)}) begin
            n_fail++; $display("FAIL bp_accept: got %0d bytes first %h expected 1 %h", got.size() - gb, got[gb], {1'b1, ref_byte(bq, 0)});
        end
    endtask

    task automatic test_back_to_back();
        bit bq[$], nq[$], mq[$], pq[$];
        int gb, ob, eb;
        start();
        gb = got.size(); ob = ok_cnt; eb = err_cnt;
        rand_bits(bq, FB);
        rand_bits(nq, 8);
        send_bits(bq);
        wc_edge(1'b1, nq[0]);
        n_checks++;
        if (ok_cnt - ob !== 1 || err_cnt - eb !== 0) begin
            n_fail++; $display("FAIL coinc_judge: got ok %0d err %0d expected 1 0", ok_cnt - ob, err_cnt - eb);
        end
        for (int i = 1; i < 8; i++) send_bit(nq[i]);
        n_checks++;
        if (got.size() - gb !== 33 || got[got.size()-1] !== {1'b1, ref_byte(nq, 0)}) begin
            n_fail++; $display("FAIL coinc_bit0: got %0d bytes last %h expected 33 %h", got.size() - gb, got[got.size()-1], {1'b1, ref_byte(nq, 0)});
        end
        // Hold one byte, then accept it in the same cycle the next one loads.
        rand_bits(mq, 8);
        rand_bits(pq, 8);
        out_ready = 1'b0;
        send_bits(mq);
        for (int i = 0; i < 7; i++) send_bit(pq[i]);
        out_ready = 1'b1; sdata = pq[7]; bitclock = 1'b1;
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, ref_byte(mq, 0)}) begin
            n_fail++; $display("FAIL b2b_pre: got %b %h expected 1 %h", out_valid, out_data, ref_byte(mq, 0));
        end
        tick(1);
        n_checks++;
        if ({out_valid, out_sof, out_data, overrun} !== {2'b10, ref_byte(pq, 0), 1'b0}) begin
            n_fail++; $display("FAIL b2b_load: got %b %b %h ovr %b expected 1 0 %h 0", out_valid, out_sof, out_data, overrun, ref_byte(pq, 0));
        end
        bitclock = 1'b0; tick(4);
        n_checks++;
        if (got.size() - gb !== 35 || got[gb+33] !== {1'b0, ref_byte(mq, 0)} || got[gb+34] !== {1'b0, ref_byte(pq, 0)}) begin
            n_fail++; $display("FAIL b2b_order: got %0d bytes expected 35 with %h %h", got.size() - gb, ref_byte(mq, 0), ref_byte(pq, 0));
        end
    endtask

    task automatic test_lock_loss();
        bit bq[$], rq[$];
        int gb, ob, eb;
        start();
        gb = got.size(); ob = ok_cnt; eb = err_cnt;
        rand_bits(bq, 100);
        send_bits(bq);
        locked = 1'b0; tick(3);
        locked = 1'b1; tick(2);
        rand_bits(rq, 8);
        send_bits(rq);
        n_checks++;
        if (got.size() - gb !== 12 || ok_cnt - ob !== 0 || err_cnt - eb !== 0) begin
            n_fail++; $display("FAIL lock_drop: got %0d bytes ok %0d err %0d expected 12 0 0", got.size() - gb, ok_cnt - ob, err_cnt - eb);
        end
        for (int k = 0; k < 12 && gb + k < got.size(); k++) begin
            n_checks++;
            if (got[gb+k] !== {k == 0, ref_byte(bq, k)}) begin
                n_fail++; $display("FAIL lock_byte%0d: got %h expected %h", k, got[gb+k], {k == 0, ref_byte(bq, k)});
            end
        end
        wc_edge(1'b0, 1'b0);
        rand_bits(rq, 8);
        send_bits(rq);
        n_checks++;
        if (got.size() - gb !== 13 || got[got.size()-1] !== {1'b1, ref_byte(rq, 0)} || ok_cnt - ob !== 0 || err_cnt - eb !== 0) begin
            n_fail++; $display("FAIL relock: got %0d bytes last %h expected 13 %h", got.size() - gb, got[got.size()-1], {1'b1, ref_byte(rq, 0)});
        end
    endtask

    task automatic test_reset_mid();
        bit bq[$];
        start();
        rand_bits(bq, 20);
        out_ready = 1'b0;
        send_bits(bq);
        n_checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got ovr %b valid %b expected 1 1", overrun, out_valid);
        end
        reset = 1'b1; tick(1);
        n_checks++;
        if ({out_data, out_sof, out_valid, frame_ok, frame_err, overrun} !== 13'd0) begin
            n_fail++; $display("FAIL rst_mid: got %h expected 0", {out_data, out_sof, out_valid, frame_ok, frame_err, overrun});
        end
        reset = 1'b0; out_ready = 1'b1; tick(2);
    endtask

    task automatic test_pulse_exclusive();
        n_checks++;
        if (both_cnt !== 0) begin n_fail++; $display("FAIL ok_err_both: got %0d cycles expected 0", both_cnt); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_nominal();
        test_msb_latency();
        test_short_long();
        test_backpressure();
        test_back_to_back();
        test_lock_loss();
        test_reset_mid();
        test_pulse_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
